// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage MIPS pipeline: detects load-use and HI/LO hazards,
// sequences stalls/flushes, tracks the multi-cycle mult/div unit and counts stall/flush cycles.
module hazard_scheduler #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_UseRT,
  input  logic [4:0]  ID_EX_RT,
  input  logic        ID_EX_MemRead,
  input  logic        ID_HILO_Read,
  input  logic        ID_MulDiv,
  input  logic        EX_MulDiv_Start,
  input  logic        EX_Branch_Taken,
  input  logic        ID_Jump,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MD_Busy,
  output logic [15:0] Stall_Count,
  output logic [15:0] Flush_Count
);

  localparam logic [7:0] MD_LAT_C = 8'(MD_LAT);

  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_t;

  md_state_t   md_state_q, md_state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic ld_haz, md_haz, stall;

  // MD FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= 8'd0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  // MD FSM: next state; a new issue always reloads the full latency
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (EX_MulDiv_Start) begin
          md_cnt_d   = MD_LAT_C;
          md_state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        if (EX_MulDiv_Start) begin
          md_cnt_d = MD_LAT_C;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
          if (md_cnt_q <= 8'd1) begin
            md_cnt_d   = 8'd0;
            md_state_d = MD_IDLE;
          end
        end
      end
      default: begin
        md_cnt_d   = 8'd0;
        md_state_d = MD_IDLE;
      end
    endcase
  end

  // MD FSM: outputs
  always_comb begin
    MD_Busy = (md_cnt_q != 8'd0);
  end

  assign ld_haz = ID_EX_MemRead && (ID_EX_RT != 5'd0) &&
                  ((ID_EX_RT == ID_RS) || (ID_UseRT && (ID_EX_RT == ID_RT)));
  assign md_haz = (MD_Busy || EX_MulDiv_Start) && (ID_HILO_Read || ID_MulDiv);
  assign stall  = (ld_haz || md_haz) && !EX_Branch_Taken;

  // Pipeline gating; reset forces bubbles into every stage while it is held
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    if (reset) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (EX_Branch_Taken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (ID_Jump) begin
      IF_ID_Flush  = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (IF_ID_Flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

endmodule
